// File: rtl/wordle_guess_scorer_pkg.sv
// Shared constants, colour codes and FSM states for the Wordle guess scorer.
// Letter codes: A=0 .. Z=25; 26..31 are invalid.
package wordle_guess_scorer_pkg;

    localparam int WORD_LEN    = 5;
    localparam int LETTER_W    = 5;
    localparam int NUM_LETTERS = 26;
    localparam int CNT_W       = 3;
    localparam int IDX_W       = 3;

    localparam logic [1:0] COL_GRAY   = 2'b00;
    localparam logic [1:0] COL_YELLOW = 2'b01;
    localparam logic [1:0] COL_GREEN  = 2'b10;

    localparam logic [LETTER_W-1:0] LAST_LETTER =
        LETTER_W'(NUM_LETTERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GREEN,
        ST_YELLOW
    } state_t;

    function automatic logic letter_ok(input logic [LETTER_W-1:0] c);
        return c <= LAST_LETTER;
    endfunction

endpackage

// File: rtl/wordle_guess_scorer_if.sv
// Request/response bundle between the game FSM (master) and the scorer (slave).
interface wordle_guess_scorer_if;
    import wordle_guess_scorer_pkg::*;

    logic                         start;
    logic [WORD_LEN*LETTER_W-1:0] guess;
    logic [WORD_LEN*LETTER_W-1:0] secret;
    logic                         busy;
    logic                         done;
    logic [2*WORD_LEN-1:0]        result;
    logic                         win;
    logic                         bad_letter;

    modport master (
        output start, guess, secret,
        input  busy, done, result, win, bad_letter
    );

    modport slave (
        input  start, guess, secret,
        output busy, done, result, win, bad_letter
    );

endinterface

// File: rtl/wordle_letter_hist.sv
// 26-entry letter histogram: saturating 3-bit counters with clear/inc/dec
// and a combinational nonzero query.
module wordle_letter_hist
    import wordle_guess_scorer_pkg::*;
(
    input  logic                board_clk,
    input  logic                reset,
    input  logic                i_clr,
    input  logic                i_inc,
    input  logic [LETTER_W-1:0] i_inc_ltr,
    input  logic                i_dec,
    input  logic [LETTER_W-1:0] i_dec_ltr,
    input  logic [LETTER_W-1:0] i_qry_ltr,
    output logic                o_nonzero
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORD_LEN);

    logic [CNT_W-1:0] r_cnt [NUM_LETTERS];
    logic             w_nonzero;

    // Invalid letter codes match no entry, so they are never counted.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LETTERS; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LETTERS; i++) begin
                if (i_clr) begin
                    r_cnt[i] <= '0;
                end else if (i_inc && i_inc_ltr == LETTER_W'(i)) begin
                    if (r_cnt[i] != CNT_MAX) r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (i_dec && i_dec_ltr == LETTER_W'(i)) begin
                    assert (r_cnt[i] != '0);
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_nonzero = 1'b0;
        for (int i = 0; i < NUM_LETTERS; i++) begin
            if (i_qry_ltr == LETTER_W'(i) && r_cnt[i] != '0)
                w_nonzero = 1'b1;
        end
    end

    assign o_nonzero = w_nonzero;

endmodule

// File: rtl/wordle_guess_scorer.sv
// Two-pass Wordle scorer: green pass fills the histogram from unmatched
// secret letters, yellow pass consumes it for the remaining guess letters.
module wordle_guess_scorer
    import wordle_guess_scorer_pkg::*;
(
    input  logic                  board_clk,
    input  logic                  reset,
    wordle_guess_scorer_if.slave  bus
);

    state_t r_state;
    state_t w_state_nxt;

    logic [IDX_W-1:0]             r_idx;
    logic [WORD_LEN*LETTER_W-1:0] r_guess;
    logic [WORD_LEN*LETTER_W-1:0] r_secret;
    logic [1:0]                   r_col [WORD_LEN];
    logic [1:0]                   w_col_nxt [WORD_LEN];

    logic                  r_busy;
    logic                  r_done;
    logic [2*WORD_LEN-1:0] r_result;
    logic                  r_win;
    logic                  r_bad;

    logic [LETTER_W-1:0] w_gl [WORD_LEN];
    logic [LETTER_W-1:0] w_sl [WORD_LEN];
    logic [LETTER_W-1:0] w_g;
    logic [LETTER_W-1:0] w_s;
    logic                w_last;
    logic                w_hit;
    logic                w_cur_green;
    logic                w_nz;
    logic                w_clr;
    logic                w_inc;
    logic                w_dec;
    logic                w_bad;
    logic                w_win;
    logic [2*WORD_LEN-1:0] w_res;

    for (genvar i = 0; i < WORD_LEN; i++) begin : g_unpack
        assign w_gl[i] = r_guess[i*LETTER_W +: LETTER_W];
        assign w_sl[i] = r_secret[i*LETTER_W +: LETTER_W];
    end

    assign w_g         = w_gl[r_idx];
    assign w_s         = w_sl[r_idx];
    assign w_last      = (r_idx == IDX_W'(WORD_LEN - 1));
    assign w_hit       = (w_g == w_s) && letter_ok(w_g);
    assign w_cur_green = (r_col[r_idx] == COL_GREEN);

    wordle_letter_hist u_hist (
        .board_clk (board_clk),
        .reset     (reset),
        .i_clr     (w_clr),
        .i_inc     (w_inc),
        .i_inc_ltr (w_s),
        .i_dec     (w_dec),
        .i_dec_ltr (w_g),
        .i_qry_ltr (w_g),
        .o_nonzero (w_nz)
    );

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (bus.start) w_state_nxt = ST_GREEN;
            ST_GREEN:  if (w_last)    w_state_nxt = ST_YELLOW;
            ST_YELLOW: if (w_last)    w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_clr = 1'b0;
        w_inc = 1'b0;
        w_dec = 1'b0;
        unique case (r_state)
            ST_IDLE:   w_clr = bus.start;
            ST_GREEN:  w_inc = !w_hit && letter_ok(w_s);
            ST_YELLOW: w_dec = !w_cur_green && letter_ok(w_g) && w_nz;
            default:   w_clr = 1'b0;
        endcase
    end

    // Working colours including the position being scored this cycle.
    always_comb begin
        for (int i = 0; i < WORD_LEN; i++) w_col_nxt[i] = r_col[i];
        if (r_state == ST_GREEN)
            w_col_nxt[r_idx] = w_hit ? COL_GREEN : COL_GRAY;
        else if (r_state == ST_YELLOW && !w_cur_green)
            w_col_nxt[r_idx] = w_dec ? COL_YELLOW : COL_GRAY;
    end

    always_comb begin
        w_bad = 1'b0;
        w_win = 1'b1;
        w_res = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            if (!letter_ok(w_gl[i]))        w_bad = 1'b1;
            if (w_col_nxt[i] != COL_GREEN)  w_win = 1'b0;
            w_res[2*i +: 2] = w_col_nxt[i];
        end
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_idx    <= '0;
            r_guess  <= '0;
            r_secret <= '0;
            for (int i = 0; i < WORD_LEN; i++) r_col[i] <= COL_GRAY;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_win    <= 1'b0;
            r_bad    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (bus.start) begin
                    r_guess  <= bus.guess;
                    r_secret <= bus.secret;
                    r_idx    <= '0;
                    r_busy   <= 1'b1;
                    for (int i = 0; i < WORD_LEN; i++) r_col[i] <= COL_GRAY;
                end
            end else begin
                for (int i = 0; i < WORD_LEN; i++) r_col[i] <= w_col_nxt[i];
                r_idx <= w_last ? '0 : r_idx + 1'b1;
                if (r_state == ST_YELLOW && w_last) begin
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_result <= w_res;
                    r_win    <= w_win;
                    r_bad    <= w_bad;
                end
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.result     = r_result;
    assign bus.win        = r_win;
    assign bus.bad_letter = r_bad;

endmodule

// File: tb/tb_wordle_guess_scorer.sv
// Scoreboard bench for wordle_guess_scorer: directed words, queued
// expectations, independent done monitor.
module tb_wordle_guess_scorer;
    import wordle_guess_scorer_pkg::*;

    typedef struct {
        logic [2*WORD_LEN-1:0] result;
        logic                  win;
        logic                  bad;
        int                    cyc;
        string                 name;
    } exp_t;

    logic board_clk = 1'b0;
    logic reset     = 1'b1;
    int   cyc       = 0;
    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   n_push    = 0;
    int   n_done    = 0;
    exp_t q[$];

    wordle_guess_scorer_if bus();

    wordle_guess_scorer dut (
        .board_clk (board_clk),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 board_clk = ~board_clk;
    always @(posedge board_clk) cyc <= cyc + 1;

    function automatic logic [WORD_LEN*LETTER_W-1:0] wd(input string s);
        logic [WORD_LEN*LETTER_W-1:0] r;
        byte b;
        r = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            b = s[i];
            r[i*LETTER_W +: LETTER_W] = LETTER_W'(b - 8'd65);
        end
        return r;
    endfunction

    function automatic logic [2*WORD_LEN-1:0] col(input string s);
        logic [2*WORD_LEN-1:0] r;
        byte b;
        r = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            b = s[i];
            if (b == "G")      r[2*i +: 2] = 2'b10;
            else if (b == "Y") r[2*i +: 2] = 2'b01;
            else               r[2*i +: 2] = 2'b00;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    task automatic chk_idle_zero(input string nm);
        chk({nm, "_busy"},   int'(bus.busy), 0);
        chk({nm, "_done"},   int'(bus.done), 0);
        chk({nm, "_result"}, int'(bus.result), 0);
        chk({nm, "_win"},    int'(bus.win), 0);
        chk({nm, "_bad"},    int'(bus.bad_letter), 0);
    endtask

    // Called at a negedge; start is sampled at the next posedge.
    task automatic issue(input string nm,
                         input logic [WORD_LEN*LETTER_W-1:0] g,
                         input logic [WORD_LEN*LETTER_W-1:0] s,
                         input string pat, input logic win, input logic bad);
        exp_t e;
        bus.guess  = g;
        bus.secret = s;
        bus.start  = 1'b1;
        e.result = col(pat);
        e.win    = win;
        e.bad    = bad;
        e.cyc    = cyc + 1 + 2*WORD_LEN;
        e.name   = nm;
        q.push_back(e);
        n_push++;
        @(negedge board_clk);
        bus.start = 1'b0;
        chk({nm, "_busy_hi"}, int'(bus.busy), 1);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge board_clk);
    endtask

    always @(negedge board_clk) begin
        exp_t e;
        if (!reset && bus.done) begin
            n_done++;
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk({e.name, "_result"}, int'(bus.result), int'(e.result));
                chk({e.name, "_win"},    int'(bus.win), int'(e.win));
                chk({e.name, "_bad"},    int'(bus.bad_letter), int'(e.bad));
                chk({e.name, "_latency"}, cyc, e.cyc);
                chk({e.name, "_busy_lo"}, int'(bus.busy), 0);
            end
        end
    end

    initial begin
        int guard;
        logic [WORD_LEN*LETTER_W-1:0] g31;
        bus.start  = 1'b0;
        bus.guess  = '0;
        bus.secret = '0;
        wait_neg(3);
        chk_idle_zero("reset");
        reset = 1'b0;
        wait_neg(2);

        issue("crane", wd("CRANE"), wd("CRANE"), "GGGGG", 1'b1, 1'b0);
        wait_neg(12);
        chk("done_pulse_one_cycle", int'(bus.done), 0);

        issue("babes", wd("BABES"), wd("ABBEY"), "YYGG-", 1'b0, 1'b0);
        wait_neg(12);

        issue("eerie", wd("EERIE"), wd("CRANE"), "--Y-G", 1'b0, 1'b0);
        wait_neg(12);

        // Restart attempt and input changes mid-scoring must be ignored.
        issue("nacre", wd("NACRE"), wd("CRANE"), "YYYYG", 1'b0, 1'b0);
        wait_neg(2);
        bus.start  = 1'b1;
        bus.guess  = wd("CRANE");
        bus.secret = wd("CRANE");
        wait_neg(1);
        bus.start  = 1'b0;
        chk("result_held_while_busy", int'(bus.result), int'(col("--Y-G")));
        wait_neg(12);

        // Reset part-way through scoring aborts with no done pulse.
        issue("aborted", wd("BABES"), wd("ABBEY"), "YYGG-", 1'b0, 1'b0);
        wait_neg(5);
        reset = 1'b1;
        #1;
        chk_idle_zero("midreset");
        void'(q.pop_back());
        n_push--;
        wait_neg(1);
        reset = 1'b0;
        wait_neg(14);
        chk("midreset_no_done", n_done, n_push);

        issue("after_reset", wd("EERIE"), wd("CRANE"), "--Y-G", 1'b0, 1'b0);
        wait_neg(12);

        g31 = wd("CRANE");
        g31[LETTER_W +: LETTER_W] = 5'd31;
        issue("bad31", g31, wd("CRANE"), "G-GGG", 1'b0, 1'b1);
        wait_neg(10);
        // Start presented in the done cycle is accepted.
        issue("b2b", wd("KEBAB"), wd("ABBEY"), "-YGYY", 1'b0, 1'b0);
        wait_neg(12);

        issue("saturate", wd("BAAAA"), wd("AAAAB"), "YGGGY", 1'b0, 1'b0);

        guard = 0;
        while (q.size() != 0 && guard < 50) begin
            @(negedge board_clk);
            guard++;
        end
        chk("queue_drained", q.size(), 0);
        chk("done_count", n_done, n_push);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
